// File: rtl/flag_blinker_pkg.sv
// Shared definitions for the LED/buzzer blink pattern generator: state encoding,
// default timing constants and a parameter range helper.
package flag_blinker_pkg;

  localparam int STATE_W       = 2;
  localparam int DEF_ON_TICKS  = 8;
  localparam int DEF_OFF_TICKS = 8;
  localparam int DEF_BLINKS    = 3;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_BLK_W     = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } blink_state_t;

  // A phase of `ticks` cycles is loaded as ticks-1, so it must fit in w bits.
  function automatic bit ticks_fit(input int ticks, input int w);
    return (ticks >= 1) && (longint'(ticks) <= (longint'(1) << w));
  endfunction

endpackage

// File: rtl/flag_blinker_timer.sv
// Load/count-down phase timer; zero is high in the last cycle of a phase.
// Loading takes effect on the next edge; no flow control.
module flag_blinker_timer
  import flag_blinker_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_d,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  assign zero = (cnt == '0);

  // Holds at zero when idle so it never wraps.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/flag_blinker.sv
// Turns a one-cycle event flag into BLINKS ON phases separated by OFF gaps, with busy/done.
// led rises one cycle after the flag; a flag while busy restarts the count at the next ON exit.
module flag_blinker
  import flag_blinker_pkg::*;
#(
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int BLINKS    = DEF_BLINKS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int BLK_W     = DEF_BLK_W
) (
  input  logic clk_d,
  input  logic rst,
  input  logic flag_in,
  output logic led,
  output logic busy,
  output logic done
);

  if (!ticks_fit(ON_TICKS, CNT_W)) begin : g_bad_on_ticks
    $error("flag_blinker: ON_TICKS out of range for CNT_W");
  end
  if (!ticks_fit(OFF_TICKS, CNT_W)) begin : g_bad_off_ticks
    $error("flag_blinker: OFF_TICKS out of range for CNT_W");
  end
  if (BLINKS < 1 || longint'(BLINKS) >= (longint'(1) << BLK_W)) begin : g_bad_blinks
    $error("flag_blinker: BLINKS must be at least 1 and fit in BLK_W");
  end

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_TICKS - 1);
  localparam logic [BLK_W-1:0] BLINKS_V = BLK_W'(BLINKS);

  blink_state_t     state;
  logic [BLK_W-1:0] blinks_left;
  logic [BLK_W-1:0] next_blinks;
  logic             restart_pending;
  logic             phase_zero;
  logic             load;
  logic [CNT_W-1:0] load_val;

  flag_blinker_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_d   (clk_d),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .zero    (phase_zero)
  );

  // blinks_left counts the ON phase in progress, so it is never zero while in ON.
  always_comb begin
    next_blinks = (restart_pending || flag_in) ? BLINKS_V : blinks_left - 1'b1;
    load        = 1'b0;
    load_val    = ON_LOAD;
    case (state)
      ST_IDLE: load = flag_in;
      ST_ON: begin
        load     = phase_zero && (next_blinks != '0);
        load_val = OFF_LOAD;
      end
      ST_OFF:  load = phase_zero;
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk_d) begin
    if (rst) begin
      state           <= ST_IDLE;
      led             <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      restart_pending <= 1'b0;
      blinks_left     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (flag_in) begin
            state       <= ST_ON;
            led         <= 1'b1;
            busy        <= 1'b1;
            blinks_left <= BLINKS_V;
          end
        end
        ST_ON: begin
          if (phase_zero) begin
            restart_pending <= 1'b0;
            blinks_left     <= next_blinks;
            led             <= 1'b0;
            if (next_blinks == '0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_OFF;
            end
          end else if (flag_in) begin
            restart_pending <= 1'b1;
          end
        end
        ST_OFF: begin
          if (flag_in) begin
            restart_pending <= 1'b1;
          end
          if (phase_zero) begin
            state <= ST_ON;
            led   <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          led   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_blinker.sv
// Bench for flag_blinker: two instances (3/2/2 and 1/2/1) checked every cycle against a
// pattern-position model, plus directed waveform checks of the timed scenarios.
module tb_flag_blinker;

  logic clk_d = 1'b0;
  logic rst;
  logic flag_in;
  logic led0, busy0, done0;
  logic led1, busy1, done1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_d = ~clk_d;

  flag_blinker #(
    .ON_TICKS(3), .OFF_TICKS(2), .BLINKS(2), .CNT_W(8), .BLK_W(4)
  ) dut (
    .clk_d(clk_d), .rst(rst), .flag_in(flag_in),
    .led(led0), .busy(busy0), .done(done0)
  );

  flag_blinker #(
    .ON_TICKS(1), .OFF_TICKS(2), .BLINKS(1), .CNT_W(8), .BLK_W(4)
  ) dut1 (
    .clk_d(clk_d), .rst(rst), .flag_in(flag_in),
    .led(led1), .busy(busy1), .done(done1)
  );

  // Model: position inside a pattern of m_n ON phases, each period = ON then OFF.
  int m_pos  [2];
  int m_n    [2];
  bit m_busy [2];
  bit m_done [2];
  bit m_pend [2];

  function automatic int p_on(input int i);  return (i == 0) ? 3 : 1; endfunction
  function automatic int p_off(input int i); return 2; endfunction
  function automatic int p_bl(input int i);  return (i == 0) ? 2 : 1; endfunction

  function automatic bit m_led(input int i);
    return m_busy[i] && ((m_pos[i] % (p_on(i) + p_off(i))) < p_on(i));
  endfunction

  task automatic model_step(input int i, input bit f, input bit r);
    int per, len;
    per = p_on(i) + p_off(i);
    if (r) begin
      m_busy[i] = 0; m_done[i] = 0; m_pend[i] = 0; m_pos[i] = 0; m_n[i] = 0;
      return;
    end
    m_done[i] = 0;
    if (!m_busy[i]) begin
      if (f) begin
        m_busy[i] = 1; m_pos[i] = 0; m_n[i] = p_bl(i);
      end
    end else if ((m_pos[i] % per) == p_on(i) - 1) begin
      if (m_pend[i] || f) begin
        // Restart: treat the rest as one ON already finished plus a full pattern.
        m_n[i] = p_bl(i) + 1; m_pos[i] = p_on(i) - 1; m_pend[i] = 0;
      end
      len = m_n[i] * p_on(i) + (m_n[i] - 1) * p_off(i);
      if (m_pos[i] == len - 1) begin
        m_busy[i] = 0; m_done[i] = 1;
      end else begin
        m_pos[i]++;
      end
    end else begin
      if (f) m_pend[i] = 1;
      m_pos[i]++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rm(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int b = lo; b <= hi; b++) m[b] = 1'b1;
    return m;
  endfunction

  logic s_led0, s_busy0, s_done0, s_led1, s_busy1, s_done1;

  // One clock cycle: drive, sample mid-cycle, compare to model, then advance the model.
  task automatic cyc(input bit f, input bit r, input bit do_chk);
    flag_in = f;
    rst     = r;
    @(negedge clk_d);
    s_led0 = led0; s_busy0 = busy0; s_done0 = done0;
    s_led1 = led1; s_busy1 = busy1; s_done1 = done1;
    if (do_chk) begin
      chk("led0",  32'(s_led0),  32'(m_led(0)));
      chk("busy0", 32'(s_busy0), 32'(m_busy[0]));
      chk("done0", 32'(s_done0), 32'(m_done[0]));
      chk("led1",  32'(s_led1),  32'(m_led(1)));
      chk("busy1", 32'(s_busy1), 32'(m_busy[1]));
      chk("done1", 32'(s_done1), 32'(m_done[1]));
    end
    @(posedge clk_d);
    model_step(0, f, r);
    model_step(1, f, r);
    #1;
  endtask

  logic [31:0] lv0, bv0, dv0, lv1, bv1, dv1;

  task automatic run_scn(input int fa, input int fb, input int ra);
    lv0 = '0; bv0 = '0; dv0 = '0; lv1 = '0; bv1 = '0; dv1 = '0;
    for (int k = 0; k < 32; k++) begin
      cyc((k == fa) || (k == fb), (k == 0) || (k == ra), 1'b1);
      lv0[k] = s_led0; bv0[k] = s_busy0; dv0[k] = s_done0;
      lv1[k] = s_led1; bv1[k] = s_busy1; dv1[k] = s_done1;
    end
  endtask

  initial begin
    int hold;
    flag_in = 1'b0;
    rst     = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);

    @(negedge clk_d);
    chk("rst_led",  32'(led0),  32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    @(posedge clk_d);
    model_step(0, 1'b0, 1'b1);
    model_step(1, 1'b0, 1'b1);
    #1;

    run_scn(10, -1, -1);
    chk("basic_led",  lv0, rm(11, 13) | rm(16, 18));
    chk("basic_busy", bv0, rm(11, 18));
    chk("basic_done", dv0, rm(19, 19));

    run_scn(10, 15, -1);
    chk("retrig_off_led",  lv0, rm(11, 13) | rm(16, 18) | rm(21, 23) | rm(26, 28));
    chk("retrig_off_busy", bv0, rm(11, 28));
    chk("retrig_off_done", dv0, rm(29, 29));

    run_scn(10, 18, -1);
    chk("retrig_exit_led",  lv0, rm(11, 13) | rm(16, 18) | rm(21, 23) | rm(26, 28));
    chk("retrig_exit_done", dv0, rm(29, 29));

    run_scn(10, 19, -1);
    chk("b2b_led",  lv0, rm(11, 13) | rm(16, 18) | rm(20, 22) | rm(25, 27));
    chk("b2b_busy", bv0, rm(11, 18) | rm(20, 27));
    chk("b2b_done", dv0, rm(19, 19) | rm(28, 28));

    run_scn(10, 20, 12);
    chk("rst_mid_led",  lv0, rm(11, 12) | rm(21, 23) | rm(26, 28));
    chk("rst_mid_busy", bv0, rm(11, 12) | rm(21, 28));
    chk("rst_mid_done", dv0, rm(29, 29));

    run_scn(5, -1, -1);
    chk("single_led",  lv1, rm(6, 6));
    chk("single_busy", bv1, rm(6, 6));
    chk("single_done", dv1, rm(7, 7));

    hold = 0;
    for (int k = 0; k < 800; k++) begin
      if (hold == 0 && $urandom_range(0, 9) == 0) hold = int'($urandom_range(1, 12));
      cyc(hold > 0, $urandom_range(0, 149) == 0, 1'b1);
      if (hold > 0) hold--;
    end
    for (int k = 0; k < 40; k++) cyc(1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
